atmega_btn_pio: RTL and testbench



---
 rtl/atmega_btn_pkg.sv | 18 +
 rtl/btn_debounce.sv | 28 ++
 rtl/atmega_btn_pio.sv | 76 +++++++
 tb/tb_atmega_btn_pio.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/atmega_btn_pkg.sv
// atmega_btn_pkg: register offsets, STAT bit positions and clog2 helper for the button port
package atmega_btn_pkg;
  localparam logic [7:0] PIN_OFS  = 8'h30;
  localparam logic [7:0] EDGE_OFS = 8'h31;
  localparam logic [7:0] IMSK_OFS = 8'h32;
  localparam logic [7:0] FIFO_OFS = 8'h33;
  localparam logic [7:0] STAT_OFS = 8'h34;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_CNT   = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus stability counter for one raw button pin
module btn_debounce import atmega_btn_pkg::*; #(
  parameter int   DEBOUNCE_CYCLES = 16000,
  parameter logic RELEASED        = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic stable_o,
  output logic upd_o
);
  localparam int CW = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  // upd_o flags the cycle in which stable flips, so the top can log the event on the same edge
  assign upd_o = (sync[1] != stable_o) && (cnt == LAST);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      sync     <= {2{RELEASED}};
      stable_o <= RELEASED;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], pin_i};
      stable_o <= stable_o ^ upd_o;
      cnt      <= (sync[1] == stable_o || upd_o) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/atmega_btn_pio.sv
// atmega_btn_pio: debounced button port with edge flags, event FIFO and interrupt on the ATmega IO bus
module atmega_btn_pio import atmega_btn_pkg::*; #(
  parameter int         CHANNELS        = 8,
  parameter int         DEBOUNCE_CYCLES = 16000,
  parameter string      ACTIVE_LOW      = "TRUE",
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [7:0] PIN_ADDR        = PIN_OFS,
  parameter logic [7:0] EDGE_ADDR       = EDGE_OFS,
  parameter logic [7:0] IMSK_ADDR       = IMSK_OFS,
  parameter logic [7:0] FIFO_ADDR       = FIFO_OFS,
  parameter logic [7:0] STAT_ADDR       = STAT_OFS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          addr_i,
  input  logic                wr_i,
  input  logic                rd_i,
  input  logic [7:0]          bus_i,
  output logic [7:0]          bus_o,
  input  logic [CHANNELS-1:0] btn_i,
  input  logic                disc_i,
  output logic [CHANNELS-1:0] btn_o,
  output logic                int_o,
  input  logic                int_ack_i
);
  localparam logic REL = (ACTIVE_LOW == "FALSE") ? 1'b0 : 1'b1;
  localparam int PW = clog2(FIFO_DEPTH);
  localparam logic [7:0] CH_MASK = 8'((1 << CHANNELS) - 1);
  logic [CHANNELS-1:0] stable, upd;
  logic [7:0] pin, pin_nxt, edg, imsk, clr, stat;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic ovf, empty, full, push, pop, push_ok;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RELEASED(REL)) u_db (
      .clk_i, .rst_i, .pin_i(btn_i[i]), .stable_o(stable[i]), .upd_o(upd[i])
    );
  end
  assign pin     = 8'(stable ^ {CHANNELS{REL}});
  assign pin_nxt = pin ^ 8'(upd);
  assign btn_o   = disc_i ? {CHANNELS{REL}} : stable;
  assign empty   = cnt == '0;
  assign full    = cnt == (PW+1)'(FIFO_DEPTH);
  assign push    = |upd;
  assign pop     = rd_i && addr_i == FIFO_ADDR && !empty;
  // a pop frees the slot the simultaneous push needs, so a full FIFO still accepts it
  assign push_ok = push && (!full || pop);
  assign clr     = (wr_i && addr_i == EDGE_ADDR ? bus_i : 8'h00) | {8{int_ack_i}};
  assign stat    = {1'b0, 3'(cnt), 1'b0, ovf, full, empty};
  assign int_o   = |(edg & imsk);
  always_comb
    bus_o = addr_i == PIN_ADDR  ? pin :
            addr_i == EDGE_ADDR ? edg :
            addr_i == IMSK_ADDR ? imsk :
            addr_i == FIFO_ADDR ? (empty ? 8'h00 : mem[rp]) :
            addr_i == STAT_ADDR ? stat : 8'h00;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      edg  <= '0;
      imsk <= '0;
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      edg  <= (edg & ~clr) | (pin_nxt & ~pin);
      imsk <= (wr_i && addr_i == IMSK_ADDR) ? bus_i & CH_MASK : imsk;
      wp   <= wp + PW'(push_ok);
      rp   <= rp + PW'(pop);
      cnt  <= cnt + (PW+1)'(push_ok) - (PW+1)'(pop);
      ovf  <= (push && !push_ok) || (ovf && !(wr_i && addr_i == STAT_ADDR && bus_i[STAT_OVF]));
    end
  always_ff @(posedge clk_i)
    if (push_ok) mem[wp] <= pin_nxt;
endmodule

// File: tb/tb_atmega_btn_pio.sv
// tb_atmega_btn_pio: directed-vector bench for the debounced button port
module tb_atmega_btn_pio;
  logic       clk_i = 1'b0, rst_i = 1'b0;
  logic [7:0] addr_i = 8'h00, bus_i = 8'h00, bus_o;
  logic [7:0] btn_i = 8'hFF, btn_o;
  logic       wr_i = 1'b0, rd_i = 1'b0, disc_i = 1'b0, int_o, int_ack_i = 1'b0;
  logic [7:0] d;
  int vec = 0, errs = 0;

  always #5 clk_i = ~clk_i;

  atmega_btn_pio #(.CHANNELS(8), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW("TRUE"), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wr_i(wr_i), .rd_i(rd_i), .bus_i(bus_i),
    .bus_o(bus_o), .btn_i(btn_i), .disc_i(disc_i), .btn_o(btn_o), .int_o(int_o), .int_ack_i(int_ack_i)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
    addr_i = a;
    #1 v = bus_o;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] v);
    addr_i = a;
    bus_i  = v;
    wr_i   = 1'b1;
    tick();
    wr_i   = 1'b0;
  endtask

  task automatic pop(output logic [7:0] v);
    addr_i = 8'h33;
    rd_i   = 1'b1;
    #1 v = bus_o;
    tick();
    rd_i   = 1'b0;
  endtask

  task automatic test_reset;
    ticks(3);
    rst_i = 1'b1;
    tick();
    vec++; if (btn_o !== 8'hFF) begin errs++; $display("FAIL reset_btn_o got %h exp %h", btn_o, 8'hFF); end
    vec++; if (int_o !== 1'b0) begin errs++; $display("FAIL reset_int got %b exp %b", int_o, 1'b0); end
    rd_reg(8'h30, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL reset_pin got %h exp %h", d, 8'h00); end
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h01) begin errs++; $display("FAIL reset_stat got %h exp %h", d, 8'h01); end
    rd_reg(8'h31, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL reset_edge got %h exp %h", d, 8'h00); end
    tick();
    rd_reg(8'h32, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL reset_imsk got %h exp %h", d, 8'h00); end
    rd_reg(8'h40, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL unmapped_read got %h exp %h", d, 8'h00); end
    wr_reg(8'h30, 8'hFF);
    rd_reg(8'h30, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL ro_write_pin got %h exp %h", d, 8'h00); end
  endtask

  task automatic test_glitch;
    btn_i[3] = 1'b0;
    ticks(7);
    btn_i[3] = 1'b1;
    ticks(20);
    rd_reg(8'h30, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL glitch_pin got %h exp %h", d, 8'h00); end
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h01) begin errs++; $display("FAIL glitch_stat got %h exp %h", d, 8'h01); end
  endtask

  task automatic test_press;
    wr_reg(8'h32, 8'h08);
    rd_reg(8'h32, d);
    vec++; if (d !== 8'h08) begin errs++; $display("FAIL imsk_rw got %h exp %h", d, 8'h08); end
    tick();
    btn_i[3] = 1'b0;
    ticks(9);
    rd_reg(8'h30, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL press_early_pin got %h exp %h", d, 8'h00); end
    vec++; if (int_o !== 1'b0) begin errs++; $display("FAIL press_early_int got %b exp %b", int_o, 1'b0); end
    tick();
    rd_reg(8'h30, d);
    vec++; if (d !== 8'h08) begin errs++; $display("FAIL press_pin got %h exp %h", d, 8'h08); end
    rd_reg(8'h31, d);
    vec++; if (d !== 8'h08) begin errs++; $display("FAIL press_edge got %h exp %h", d, 8'h08); end
    vec++; if (int_o !== 1'b1) begin errs++; $display("FAIL press_int got %b exp %b", int_o, 1'b1); end
    vec++; if (btn_o !== 8'hF7) begin errs++; $display("FAIL press_btn_o got %h exp %h", btn_o, 8'hF7); end
    tick();
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h10) begin errs++; $display("FAIL press_stat got %h exp %h", d, 8'h10); end
    pop(d);
    vec++; if (d !== 8'h08) begin errs++; $display("FAIL press_pop got %h exp %h", d, 8'h08); end
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h01) begin errs++; $display("FAIL press_stat_after_pop got %h exp %h", d, 8'h01); end
    wr_reg(8'h31, 8'h08);
    vec++; if (int_o !== 1'b0) begin errs++; $display("FAIL w1c_int got %b exp %b", int_o, 1'b0); end
    rd_reg(8'h31, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL w1c_edge got %h exp %h", d, 8'h00); end
    btn_i[3] = 1'b1;
    ticks(12);
    pop(d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL release_pop got %h exp %h", d, 8'h00); end
  endtask

  task automatic test_overflow;
    logic [7:0] seq_btn [5];
    logic [7:0] seq_exp [4];
    seq_btn = '{8'hFE, 8'hFC, 8'hFD, 8'hFF, 8'hFB};
    seq_exp = '{8'h01, 8'h03, 8'h02, 8'h00};
    for (int i = 0; i < 5; i++) begin
      btn_i = seq_btn[i];
      ticks(12);
    end
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h46) begin errs++; $display("FAIL ovf_stat got %h exp %h", d, 8'h46); end
    for (int i = 0; i < 4; i++) begin
      pop(d);
      vec++; if (d !== seq_exp[i]) begin errs++; $display("FAIL ovf_pop%0d got %h exp %h", i, d, seq_exp[i]); end
    end
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h05) begin errs++; $display("FAIL ovf_stat_empty got %h exp %h", d, 8'h05); end
    pop(d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL empty_pop got %h exp %h", d, 8'h00); end
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h05) begin errs++; $display("FAIL empty_pop_stat got %h exp %h", d, 8'h05); end
    wr_reg(8'h34, 8'h04);
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h01) begin errs++; $display("FAIL ovf_clear got %h exp %h", d, 8'h01); end
    rd_reg(8'h31, d);
    vec++; if (d !== 8'h07) begin errs++; $display("FAIL ovf_edge got %h exp %h", d, 8'h07); end
    vec++; if (int_o !== 1'b0) begin errs++; $display("FAIL masked_int got %b exp %b", int_o, 1'b0); end
    int_ack_i = 1'b1;
    tick();
    int_ack_i = 1'b0;
    rd_reg(8'h31, d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL ack_edge got %h exp %h", d, 8'h00); end
  endtask

  task automatic test_disc;
    btn_i = 8'hFF;
    ticks(12);
    pop(d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL disc_pre_pop got %h exp %h", d, 8'h00); end
    disc_i = 1'b1;
    btn_i  = 8'hFE;
    ticks(12);
    vec++; if (btn_o !== 8'hFF) begin errs++; $display("FAIL disc_btn_o got %h exp %h", btn_o, 8'hFF); end
    rd_reg(8'h30, d);
    vec++; if (d !== 8'h01) begin errs++; $display("FAIL disc_pin got %h exp %h", d, 8'h01); end
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h10) begin errs++; $display("FAIL disc_stat got %h exp %h", d, 8'h10); end
    pop(d);
    vec++; if (d !== 8'h01) begin errs++; $display("FAIL disc_pop got %h exp %h", d, 8'h01); end
    disc_i = 1'b0;
    #1;
    vec++; if (btn_o !== 8'hFE) begin errs++; $display("FAIL reconnect_btn_o got %h exp %h", btn_o, 8'hFE); end
    btn_i = 8'hFF;
    ticks(12);
    pop(d);
    vec++; if (d !== 8'h00) begin errs++; $display("FAIL disc_release_pop got %h exp %h", d, 8'h00); end
    wr_reg(8'h31, 8'hFF);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q [4];
    exp_q = '{8'h00, 8'h20, 8'h00, 8'h40};
    btn_i = 8'hEF;
    ticks(9);
    addr_i    = 8'h31;
    bus_i     = 8'h10;
    wr_i      = 1'b1;
    int_ack_i = 1'b1;
    tick();
    wr_i      = 1'b0;
    int_ack_i = 1'b0;
    rd_reg(8'h31, d);
    vec++; if (d !== 8'h10) begin errs++; $display("FAIL set_beats_clear got %h exp %h", d, 8'h10); end
    btn_i = 8'hFF;
    ticks(12);
    btn_i = 8'hDF;
    ticks(12);
    btn_i = 8'hFF;
    ticks(12);
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h42) begin errs++; $display("FAIL b2b_full_stat got %h exp %h", d, 8'h42); end
    btn_i = 8'hBF;
    ticks(9);
    addr_i = 8'h33;
    rd_i   = 1'b1;
    #1 d = bus_o;
    vec++; if (d !== 8'h10) begin errs++; $display("FAIL b2b_pop got %h exp %h", d, 8'h10); end
    tick();
    rd_i = 1'b0;
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h42) begin errs++; $display("FAIL b2b_stat got %h exp %h", d, 8'h42); end
    for (int i = 0; i < 4; i++) begin
      pop(d);
      vec++; if (d !== exp_q[i]) begin errs++; $display("FAIL b2b_pop%0d got %h exp %h", i, d, exp_q[i]); end
    end
    rd_reg(8'h34, d);
    vec++; if (d !== 8'h01) begin errs++; $display("FAIL b2b_drained got %h exp %h", d, 8'h01); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_overflow();
    test_disc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
